// File: rtl/image_sched.sv
// image_sched: layer scheduler between the host config bus and image_read.
// Latches a layer descriptor from the host. On start it replays the descriptor
// into image_read's config registers, then issues one ir_next per pass and
// counts passes by watching the accepted last image beat.
// Ports:
//   clk, rst (async, active low)
//   cfg_data/cfg_addr/cfg_valid   host descriptor writes (accepted in IDLE)
//   start, abort                  layer control
//   busy, done, pass_cnt          status
//   ir_cfg_data/addr/valid        config writes to image_read
//   ir_next, ir_next_rdy          pass request handshake
//   ir_image_last/val/rdy         monitored image stream
module image_sched #(
    parameter int                    CFG_DWIDTH    = 32,
    parameter int                    CFG_AWIDTH    = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_IS_IMG_W  = 5'd16,
    parameter logic [CFG_AWIDTH-1:0] CFG_IS_IMG_DH = 5'd17,
    parameter logic [CFG_AWIDTH-1:0] CFG_IS_PAD    = 5'd18,
    parameter logic [CFG_AWIDTH-1:0] CFG_IS_CONV   = 5'd19,
    parameter logic [CFG_AWIDTH-1:0] CFG_IS_PASS   = 5'd20,
    parameter logic [CFG_AWIDTH-1:0] IR_IMG_W      = 5'd0,
    parameter logic [CFG_AWIDTH-1:0] IR_IMG_DH     = 5'd1,
    parameter logic [CFG_AWIDTH-1:0] IR_PAD        = 5'd2,
    parameter logic [CFG_AWIDTH-1:0] IR_CONV       = 5'd3,
    parameter int                    PASS_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_DWIDTH-1:0] cfg_data,
    input  logic [CFG_AWIDTH-1:0] cfg_addr,
    input  logic                  cfg_valid,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [PASS_WIDTH-1:0] pass_cnt,
    output logic [CFG_DWIDTH-1:0] ir_cfg_data,
    output logic [CFG_AWIDTH-1:0] ir_cfg_addr,
    output logic                  ir_cfg_valid,
    output logic                  ir_next,
    input  logic                  ir_next_rdy,
    input  logic                  ir_image_last,
    input  logic                  ir_image_val,
    input  logic                  ir_image_rdy
);

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_ISSUE, S_RUN, S_DONE} state_t;

    state_t                state, state_n;
    logic [1:0]            idx, idx_n, rep_sel;
    logic [CFG_DWIDTH-1:0] sh_w, sh_dh, sh_pad, sh_conv;
    logic [CFG_DWIDTH-1:0] sh_w_n, sh_dh_n, sh_pad_n, sh_conv_n;
    logic [PASS_WIDTH-1:0] sh_pass, sh_pass_n, pass_cnt_n;
    logic [CFG_DWIDTH-1:0] rep_data, cfg_data_n;
    logic [CFG_AWIDTH-1:0] rep_addr, cfg_addr_n;
    logic                  cfg_valid_n, next_n, busy_n, done_n;
    logic                  host_wr, beat_last;
    logic [PASS_WIDTH:0]   pass_inc, pass_tgt;

    assign host_wr   = cfg_valid && (state == S_IDLE);
    assign beat_last = ir_image_val && ir_image_rdy && ir_image_last;
    // One extra bit so that P = all-ones means 2^PASS_WIDTH passes, not zero.
    assign pass_inc  = {1'b0, pass_cnt} + (PASS_WIDTH+1)'(1);
    assign pass_tgt  = {1'b0, sh_pass} + (PASS_WIDTH+1)'(1);

    // Shadow next-values; replay reads these so a host write landing on the
    // start edge is already visible to the first config write.
    always_comb begin
        sh_w_n    = sh_w;
        sh_dh_n   = sh_dh;
        sh_pad_n  = sh_pad;
        sh_conv_n = sh_conv;
        sh_pass_n = sh_pass;
        if (host_wr) begin
            if (cfg_addr == CFG_IS_IMG_W)  sh_w_n    = cfg_data;
            if (cfg_addr == CFG_IS_IMG_DH) sh_dh_n   = cfg_data;
            if (cfg_addr == CFG_IS_PAD)    sh_pad_n  = cfg_data;
            if (cfg_addr == CFG_IS_CONV)   sh_conv_n = cfg_data;
            if (cfg_addr == CFG_IS_PASS)   sh_pass_n = cfg_data[PASS_WIDTH-1:0];
        end
    end

    always_comb begin
        rep_data = sh_w_n;
        rep_addr = IR_IMG_W;
        case (rep_sel)
            2'd1:    begin rep_data = sh_dh_n;   rep_addr = IR_IMG_DH; end
            2'd2:    begin rep_data = sh_pad_n;  rep_addr = IR_PAD;    end
            2'd3:    begin rep_data = sh_conv_n; rep_addr = IR_CONV;   end
            default: begin rep_data = sh_w_n;    rep_addr = IR_IMG_W;  end
        endcase
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        rep_sel     = idx + 2'd1;
        pass_cnt_n  = pass_cnt;
        cfg_valid_n = 1'b0;
        cfg_addr_n  = ir_cfg_addr;
        cfg_data_n  = ir_cfg_data;
        next_n      = 1'b0;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state_n     = S_CFG;
                    idx_n       = 2'd0;
                    rep_sel     = 2'd0;
                    pass_cnt_n  = '0;
                    cfg_valid_n = 1'b1;
                    cfg_addr_n  = rep_addr;
                    cfg_data_n  = rep_data;
                end
                // idx is the write currently on the bus
                S_CFG: if (idx == 2'd3) begin
                    state_n = S_ISSUE;
                end else begin
                    idx_n       = idx + 2'd1;
                    cfg_valid_n = 1'b1;
                    cfg_addr_n  = rep_addr;
                    cfg_data_n  = rep_data;
                end
                S_ISSUE: if (ir_next_rdy) begin
                    next_n  = 1'b1;
                    state_n = S_RUN;
                end
                S_RUN: if (beat_last) begin
                    pass_cnt_n = pass_inc[PASS_WIDTH-1:0];
                    state_n    = (pass_inc == pass_tgt) ? S_DONE : S_ISSUE;
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            sh_w         <= '0;
            sh_dh        <= '0;
            sh_pad       <= '0;
            sh_conv      <= '0;
            sh_pass      <= '0;
            pass_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ir_cfg_valid <= 1'b0;
            ir_cfg_addr  <= '0;
            ir_cfg_data  <= '0;
            ir_next      <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            sh_w         <= sh_w_n;
            sh_dh        <= sh_dh_n;
            sh_pad       <= sh_pad_n;
            sh_conv      <= sh_conv_n;
            sh_pass      <= sh_pass_n;
            pass_cnt     <= pass_cnt_n;
            busy         <= busy_n;
            done         <= done_n;
            ir_cfg_valid <= cfg_valid_n;
            ir_cfg_addr  <= cfg_addr_n;
            ir_cfg_data  <= cfg_data_n;
            ir_next      <= next_n;
        end
    end

endmodule
